siso_shift_register: RTL and testbench
======================================

SISO_SHIFT_REGISTER -- requirements
Module: siso_shift_register

Interface
REQ-001 Parameter DEPTH, default 4, number of shift stages; legal range 1..64.
REQ-002 Parameter RESET_VAL, default 1'b0, value loaded into every stage during reset.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset, asynchronous, active-low (0 = reset asserted).
REQ-005 s_in  input  1  serial data in, sampled on each rising clk edge.
REQ-006 s_out  output  1  serial data out, driven directly by the last stage register.
REQ-007 Ports SHALL be declared in the order s_in, clk, rst, s_out so that existing positional instantiations remain valid.

Function
REQ-008 The block SHALL hold a DEPTH-bit shift chain, stage[0] to stage[DEPTH-1].
REQ-009 On each rising clk edge with rst=1, stage[0] SHALL load s_in and stage[k] SHALL load stage[k-1] for k=1..DEPTH-1.
REQ-010 s_out SHALL equal stage[DEPTH-1] with no combinational path from s_in.
REQ-011 A bit sampled at rising edge n SHALL appear on s_out after rising edge n+DEPTH-1, i.e. DEPTH edges including the sampling edge.
REQ-012 Bit order SHALL be preserved: the first bit in is the first bit out (FIFO order).
REQ-013 No enable exists; the chain SHALL shift on every rising edge while out of reset.
REQ-014 With DEPTH=1, s_out SHALL be a single registered copy of s_in (1-cycle delay).
REQ-015 An X or Z value on s_in SHALL propagate unchanged through the chain in simulation; no masking.

Reset
REQ-016 When rst falls to 0, all stages SHALL take RESET_VAL immediately, independent of clk, so s_out=0 at default.
REQ-017 While rst=0, stages SHALL hold RESET_VAL and ignore s_in and clk edges.
REQ-018 Reset asserted mid-stream SHALL discard all in-flight bits; after release, s_out SHALL show RESET_VAL until new data has traversed DEPTH edges.
REQ-019 The first shift after release SHALL occur on the first rising clk edge sampled with rst=1.
REQ-020 The release of rst SHALL be synchronized to clk outside this block; no internal synchronizer is required.

Structure
REQ-021 Package siso_pkg SHALL hold SISO_DEPTH_DEFAULT (4) and SISO_RESET_VAL_DEFAULT (1'b0); module parameter defaults SHALL reference them.
REQ-022 Sub-module siso_dff (1-bit D flop, async active-low reset to a parameter value) SHALL be instantiated DEPTH times via a generate loop.
REQ-023 Elaboration SHALL fail with an error if DEPTH < 1 or DEPTH > 64.
REQ-024 The block SHALL contain no latches and no logic beyond the flop chain.

Verification
REQ-025 Assert rst=0 for 1 cycle with s_in=1 -> s_out=0 immediately and throughout; no shift occurs during reset.
REQ-026 After release, drive 4'b1101 LSB-first (s_in 1,0,1,1 on consecutive edges, then 0) -> s_out reads 1,0,1,1 on edges 4..7 after the first data edge.
REQ-027 Hold s_in=1 for 10 edges -> s_out=0 for the first 3 edges, then 1 from edge 4 onward.
REQ-028 Stream 1,1,1 and assert rst=0 between clock edges -> s_out drops to 0 without waiting for an edge; after release, the next 3 edges keep s_out=0 with s_in=0.
REQ-029 Set DEPTH=1 and toggle s_in 0,1,0,1 -> s_out follows one edge later; set DEPTH=8 and send a single 1 -> s_out pulses high for exactly one cycle, 8 edges after sampling.

Source files
------------

// File: rtl/siso_shift_register_pkg.sv
// -----------------------------------------------------------------------------
// siso_pkg
// Shared constants for the serial-in / serial-out shift register.
//   SISO_DEPTH_DEFAULT     : default number of shift stages
//   SISO_RESET_VAL_DEFAULT : default value held by every stage in reset
//   SISO_DEPTH_MIN/MAX     : legal DEPTH range, checked at elaboration
// -----------------------------------------------------------------------------
package siso_pkg;

    localparam int   SISO_DEPTH_DEFAULT     = 4;
    localparam logic SISO_RESET_VAL_DEFAULT = 1'b0;
    localparam int   SISO_DEPTH_MIN         = 1;
    localparam int   SISO_DEPTH_MAX         = 64;

endpackage : siso_pkg

// File: rtl/siso_shift_register_if.sv
// -----------------------------------------------------------------------------
// siso_shift_register_if
// Groups the serial data pair of the shift register.
//   s_in  : serial data into the chain
//   s_out : serial data out of the last stage
// Modports:
//   master : the side producing s_in and consuming s_out (e.g. a driver)
//   slave  : the shift register side
// The shift register itself keeps plain ports so that existing positional
// instantiations stay valid; this interface bundles the pair for users of it.
// -----------------------------------------------------------------------------
interface siso_shift_register_if;

    logic s_in;
    logic s_out;

    modport master (output s_in, input s_out);
    modport slave  (input s_in, output s_out);

endinterface : siso_shift_register_if

// File: rtl/siso_dff.sv
// -----------------------------------------------------------------------------
// siso_dff
// One-bit D flip-flop with asynchronous active-low reset to a parameter value.
//   clk   : rising-edge clock
//   rst_n : asynchronous reset, active low; forces q_o to RESET_VAL
//   d_i   : data input
//   q_o   : registered output
// -----------------------------------------------------------------------------
module siso_dff #(
    parameter logic RESET_VAL = 1'b0
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o
);

    logic q_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            q_q <= RESET_VAL;
        end else begin
            q_q <= d_i;
        end
    end

    assign q_o = q_q;

endmodule : siso_dff

// File: rtl/siso_shift_register.sv
// -----------------------------------------------------------------------------
// siso_shift_register
// DEPTH-stage serial-in / serial-out shift register. A bit sampled on a rising
// edge appears on s_out after DEPTH rising edges (counting the sampling edge),
// first in first out. No enable: the chain shifts on every edge out of reset.
//   s_in  : serial data in, sampled on each rising clk edge
//   clk   : single clock
//   rst   : asynchronous reset, active low; all stages go to RESET_VAL at once
//   s_out : last stage register, no combinational path from s_in
// Port order is kept as s_in, clk, rst, s_out for positional instantiations.
// The release of rst is expected to be synchronized to clk by the parent.
// -----------------------------------------------------------------------------
module siso_shift_register
    import siso_pkg::*;
#(
    parameter int   DEPTH     = SISO_DEPTH_DEFAULT,
    parameter logic RESET_VAL = SISO_RESET_VAL_DEFAULT
) (
    input  logic s_in,
    input  logic clk,
    input  logic rst,
    output logic s_out
);

    if ((DEPTH < SISO_DEPTH_MIN) || (DEPTH > SISO_DEPTH_MAX)) begin : g_depth_check
        $error("siso_shift_register: DEPTH=%0d outside legal range %0d..%0d",
               DEPTH, SISO_DEPTH_MIN, SISO_DEPTH_MAX);
    end

    // stage_q[0] is the input end, stage_q[DEPTH-1] drives s_out.
    logic [DEPTH-1:0] stage_q;

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi = gi + 1) begin : g_stage
            logic stage_d;

            // Stage 0 is fed from the serial input; every other stage from
            // its predecessor. Split so no index ever goes negative.
            if (gi == 0) begin : g_first
                assign stage_d = s_in;
            end else begin : g_rest
                assign stage_d = stage_q[gi-1];
            end

            siso_dff #(
                .RESET_VAL (RESET_VAL)
            ) u_dff (
                .clk   (clk),
                .rst_n (rst),
                .d_i   (stage_d),
                .q_o   (stage_q[gi])
            );
        end
    endgenerate

    assign s_out = stage_q[DEPTH-1];

endmodule : siso_shift_register

// File: tb/tb_siso_shift_register.sv
// -----------------------------------------------------------------------------
// tb_siso_shift_register
// Drives three shift registers (DEPTH 4, 1 and 8) with a common serial stream
// and reset. Each has a queue holding the expected chain contents, oldest bit
// at the front: every shifting edge pushes the driven bit and pops the oldest,
// and the front is the value s_out must show after that edge.
// -----------------------------------------------------------------------------
module tb_siso_shift_register;

    logic clk;
    logic rst;

    siso_shift_register_if if4 ();
    siso_shift_register_if if1 ();
    siso_shift_register_if if8 ();

    siso_shift_register #(.DEPTH(4), .RESET_VAL(1'b0)) dut4 (
        .s_in  (if4.s_in),
        .clk   (clk),
        .rst   (rst),
        .s_out (if4.s_out)
    );

    siso_shift_register #(.DEPTH(1), .RESET_VAL(1'b0)) dut1 (
        .s_in  (if1.s_in),
        .clk   (clk),
        .rst   (rst),
        .s_out (if1.s_out)
    );

    siso_shift_register #(.DEPTH(8), .RESET_VAL(1'b0)) dut8 (
        .s_in  (if8.s_in),
        .clk   (clk),
        .rst   (rst),
        .s_out (if8.s_out)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int total_cnt = 0;
    int pass_cnt  = 0;

    logic q4[$];
    logic q1[$];
    logic q8[$];

    task automatic check_bit(input string tag, input logic obs, input logic exp);
        total_cnt++;
        if (obs === exp) begin
            pass_cnt++;
        end else begin
            $display("FAIL %s: got %b expected %b at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic reset_models();
        q4.delete();
        q1.delete();
        q8.delete();
        for (int i = 0; i < 4; i++) q4.push_back(1'b0);
        q1.push_back(1'b0);
        for (int i = 0; i < 8; i++) q8.push_back(1'b0);
    endtask

    task automatic check_all(input string tag);
        check_bit({tag, "/d4"}, if4.s_out, q4[0]);
        check_bit({tag, "/d1"}, if1.s_out, q1[0]);
        check_bit({tag, "/d8"}, if8.s_out, q8[0]);
    endtask

    // Drive one bit, take one rising edge, update the models, check 1 ns later.
    task automatic step(input logic v, input string tag);
        logic shifting;
        if4.s_in = v;
        if1.s_in = v;
        if8.s_in = v;
        @(posedge clk);
        shifting = rst;
        if (shifting) begin
            q4.push_back(v); void'(q4.pop_front());
            q1.push_back(v); void'(q1.pop_front());
            q8.push_back(v); void'(q8.pop_front());
        end
        #1;
        $display("step %-10s s_in=%b rst=%b s_out d4=%b d1=%b d8=%b",
                 tag, v, rst, if4.s_out, if1.s_out, if8.s_out);
        check_all(tag);
    endtask

    // Assert reset between edges and check the outputs fall without an edge.
    task automatic async_reset(input string tag);
        #3;
        rst = 1'b0;
        reset_models();
        #1;
        $display("reset %-9s asserted between edges s_out d4=%b d1=%b d8=%b",
                 tag, if4.s_out, if1.s_out, if8.s_out);
        check_all({tag, "_async"});
        #2;
        rst = 1'b1;
    endtask

    initial begin
        logic [3:0] pat;
        rst = 1'b0;
        if4.s_in = 1'b1;
        if1.s_in = 1'b1;
        if8.s_in = 1'b1;
        reset_models();
        #2;
        check_all("reset_init");

        // Edges during reset with s_in=1 must not shift anything in.
        step(1'b1, "in_reset");
        step(1'b1, "in_reset");

        // Release between edges, then 1101 LSB-first followed by zeros.
        #4;
        rst = 1'b1;
        pat = 4'b1101;
        for (int i = 0; i < 4; i++) step(pat[i], "pat1101");
        for (int i = 0; i < 8; i++) step(1'b0, "pat_tail");

        // Constant one for 10 edges.
        for (int i = 0; i < 10; i++) step(1'b1, "hold_one");
        for (int i = 0; i < 8; i++) step(1'b0, "flush");

        // Stream 1,1,1, reset mid-cycle, then three zero edges.
        for (int i = 0; i < 3; i++) step(1'b1, "pre_rst");
        async_reset("midstream");
        for (int i = 0; i < 3; i++) step(1'b0, "post_rst");

        // Toggle pattern and a single-bit pulse.
        for (int i = 0; i < 4; i++) step(logic'(i % 2), "toggle");
        for (int i = 0; i < 8; i++) step(1'b0, "gap");
        step(1'b1, "pulse");
        for (int i = 0; i < 10; i++) step(1'b0, "pulse_tail");

        // Random traffic with one more asynchronous reset in the middle.
        for (int i = 0; i < 30; i++) step(logic'($urandom_range(0, 1)), "random");
        async_reset("random");
        for (int i = 0; i < 30; i++) step(logic'($urandom_range(0, 1)), "random2");

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule : tb_siso_shift_register
